// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and hazard_ctrl:
// stage register addresses/control bits in, forwarding selects and stall/flush out.
interface hazard_ctrl_if;
  logic [4:0] rs1D, rs2D;
  logic [4:0] rs1E, rs2E, rdE;
  logic [1:0] ResultSrcE;
  logic [4:0] rdM, rdW;
  logic       RegWriteM, RegWriteW;
  logic       PCSrcE;
  logic       MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, ResultSrcE, rdM, rdW,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, ResultSrcE, rdM, rdW,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use/branch/memory-wait stall and
// flush generation, data-memory watchdog and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       lw_stall, mem_stall, freeze, stall_f;

    always_comb begin
        hz.ForwardAE = 2'b00;
        if (hz.RegWriteM && hz.rdM != '0 && hz.rdM == hz.rs1E)
            hz.ForwardAE = 2'b10;
        else if (hz.RegWriteW && hz.rdW != '0 && hz.rdW == hz.rs1E)
            hz.ForwardAE = 2'b01;
    end

    always_comb begin
        hz.ForwardBE = 2'b00;
        if (hz.RegWriteM && hz.rdM != '0 && hz.rdM == hz.rs2E)
            hz.ForwardBE = 2'b10;
        else if (hz.RegWriteW && hz.rdW != '0 && hz.rdW == hz.rs2E)
            hz.ForwardBE = 2'b01;
    end

    assign lw_stall  = (hz.ResultSrcE == 2'b01) && (hz.rdE != '0) &&
                       ((hz.rs1D == hz.rdE) || (hz.rs2D == hz.rdE));
    assign mem_stall = hz.MemReqM && !hz.MemReadyM;
    // During reset the state is treated as RUN so the outputs track the inputs only.
    assign freeze    = mem_stall || (state == ERR && !reset);

    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        hz.FlushW = 1'b0;
        if (freeze) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.StallE = 1'b1;
            hz.StallM = 1'b1;
            hz.FlushW = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.FlushD = 1'b1;
            hz.FlushE = 1'b1;
        end else if (lw_stall) begin
            hz.StallF = 1'b1;
            hz.StallD = 1'b1;
            hz.FlushE = 1'b1;
        end
    end

    assign stall_f = freeze || (lw_stall && !hz.PCSrcE);

    // wait_cnt counts every stalled memory cycle including the first one spent in RUN,
    // so ERR is reached at the edge ending the MEM_TIMEOUT-th consecutive wait cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt == WAIT_LAST) begin
                            state       <= ERR;
                            mem_timeout <= 1'b1;
                        end else begin
                            state    <= MEM_WAIT;
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else if (state == RUN || hz.MemReadyM) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: state <= ERR;
            endcase

            if (stall_f && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (hz.PCSrcE && !freeze && flush_events != '1)
                flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a queue scoreboard of expected controls and counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_timeout;
    logic [3:0] stall_cycles, flush_events;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .hz           (hz.slave),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [11:0] ctrl;
        logic [3:0]  sc;
        logic [3:0]  fe;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // {FAE, FBE, SF, SD, SE, SM, FD, FE, FW, mem_timeout}
    function automatic logic [11:0] ctl(logic [1:0] fa, logic [1:0] fb, logic sf, logic sd,
                                        logic se, logic sm, logic fd, logic fe, logic fw,
                                        logic mt);
        return {fa, fb, sf, sd, se, sm, fd, fe, fw, mt};
    endfunction

    function automatic logic [11:0] obs_ctrl();
        return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                hz.FlushD, hz.FlushE, hz.FlushW, mem_timeout};
    endfunction

    localparam logic [11:0] FRZ = 12'b0000_1111_0010;

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        n_assert++;
        assert (obs_ctrl() === e.ctrl) else begin
            n_fail++;
            $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs_ctrl(), e.ctrl);
        end
        n_assert++;
        assert ({stall_cycles, flush_events} === {e.sc, e.fe}) else begin
            n_fail++;
            $error("FAIL %s counters observed=%0d/%0d expected=%0d/%0d",
                   e.tag, stall_cycles, flush_events, e.sc, e.fe);
        end
    endtask

    task automatic step(string tag, logic [11:0] c, int sc, int fe);
        exp_t e;
        e.tag  = tag;
        e.ctrl = c;
        e.sc   = 4'(sc);
        e.fe   = 4'(fe);
        sb.push_back(e);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.rs1D = '0; hz.rs2D = '0; hz.rs1E = '0; hz.rs2E = '0; hz.rdE = '0;
        hz.ResultSrcE = '0; hz.rdM = '0; hz.rdW = '0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.PCSrcE = 1'b0;
        hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        clr();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        step("reset_state", 12'd0, 0, 0);
        reset = 1'b0;

        // Forwarding
        hz.RegWriteM = 1'b1; hz.rdM = 5'd5; hz.RegWriteW = 1'b1; hz.rdW = 5'd5; hz.rs1E = 5'd5;
        step("fwdA_mem_prio", ctl(2'b10, 2'b00, 0,0,0,0,0,0,0,0), 0, 0);
        hz.rdM = 5'd0; hz.rdW = 5'd0; hz.rs2E = 5'd0;
        step("fwdB_x0", 12'd0, 0, 0);
        hz.rdM = 5'd3; hz.rdW = 5'd7; hz.rs2E = 5'd7; hz.rs1E = 5'd3;
        step("fwd_mem_wb", ctl(2'b10, 2'b01, 0,0,0,0,0,0,0,0), 0, 0);
        hz.RegWriteM = 1'b0; hz.rdM = 5'd7;
        step("fwdB_nowrite_mem", ctl(2'b00, 2'b01, 0,0,0,0,0,0,0,0), 0, 0);
        clr();

        // Load-use
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd4; hz.rs2D = 5'd4;
        step("loaduse", ctl(0, 0, 1,1,0,0,0,1,0,0), 0, 0);
        clr();
        step("loaduse_after", 12'd0, 1, 0);
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd0; hz.rs2D = 5'd0;
        step("loaduse_x0", 12'd0, 1, 0);
        clr();

        // Branch
        hz.PCSrcE = 1'b1;
        step("branch", ctl(0, 0, 0,0,0,0,1,1,0,0), 1, 0);
        clr();
        step("branch_after", 12'd0, 1, 1);
        hz.PCSrcE = 1'b1; hz.ResultSrcE = 2'b01; hz.rdE = 5'd4; hz.rs1D = 5'd4;
        step("branch_beats_lw", ctl(0, 0, 0,0,0,0,1,1,0,0), 1, 1);
        clr();

        // Memory wait of 3 cycles with a branch held in EX
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0; hz.PCSrcE = 1'b1;
        step("memwait1", FRZ, 1, 2);
        step("memwait2", FRZ, 2, 2);
        step("memwait3", FRZ, 3, 2);
        hz.MemReadyM = 1'b1;
        step("memwait_release", ctl(0, 0, 0,0,0,0,1,1,0,0), 4, 2);
        clr();
        step("memwait_after", 12'd0, 4, 3);

        // Watchdog
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        step("wd1", FRZ, 4, 3);
        step("wd2", FRZ, 5, 3);
        step("wd3", FRZ, 6, 3);
        step("wd4", FRZ, 7, 3);
        hz.MemReqM = 1'b0; hz.MemReadyM = 1'b1;
        step("wd_err", FRZ | 12'd1, 8, 3);
        step("wd_err_hold", FRZ | 12'd1, 9, 3);
        clr();
        reset = 1'b1;
        step("wd_in_reset", 12'd1, 10, 3);
        reset = 1'b0;
        step("wd_after_reset", 12'd0, 0, 0);

        // Saturation of stall_cycles
        hz.ResultSrcE = 2'b01; hz.rdE = 5'd4; hz.rs1D = 5'd4;
        for (int i = 0; i < 20; i++)
            step($sformatf("sat%0d", i), ctl(0, 0, 1,1,0,0,0,1,0,0), (i > 15) ? 15 : i, 0);
        clr();
        step("sat_final", 12'd0, 15, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
